// File: rtl/icache_pkg.sv
// Shared definitions for the L1 instruction cache and its refill controller.
// Direct-mapped, 16 lines x 8 bytes; a 32-bit address splits into
// tag [31:7], index [6:3], offset [2:0].
package icache_pkg;

    localparam int unsigned LINE_BYTES  = 8;
    localparam int unsigned OFFSET_BITS = 3;
    localparam int unsigned INDEX_BITS  = 4;
    localparam int unsigned TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;

    // Address-field slicing positions, shared with the cache array.
    localparam int unsigned INDEX_LSB = OFFSET_BITS;
    localparam int unsigned TAG_LSB   = OFFSET_BITS + INDEX_BITS;

    // Each line is fetched as two 32-bit beats.
    localparam logic [31:0] BEAT_BYTES = 32'd4;

    typedef enum logic [2:0] {
        StIdle,
        StReqLo,
        StWaitLo,
        StReqHi,
        StWaitHi,
        StFill
    } refill_state_e;

endpackage

// File: rtl/icache_refill_controller_if.sv
// Beat-read bus between the refill controller and backing memory.
//   memReq/memAddr      : request valid and word-aligned beat address
//   memReady            : memory accepts the request this cycle
//   memRespValid/Data   : read data beat, at least one cycle after acceptance
interface icache_refill_controller_if;

    logic        memReq;
    logic [31:0] memAddr;
    logic        memReady;
    logic        memRespValid;
    logic [31:0] memRespData;

    modport master (
        output memReq,
        output memAddr,
        input  memReady,
        input  memRespValid,
        input  memRespData
    );

    modport slave (
        input  memReq,
        input  memAddr,
        output memReady,
        output memRespValid,
        output memRespData
    );

endinterface

// File: rtl/icache_refill_controller.sv
// Miss handler and refill sequencer for the direct-mapped L1 instruction cache.
// On a fetch miss it stalls fetch, reads the 8-byte line as two 32-bit beats,
// then pulses the cache write port for one cycle. Keeps a saturating miss count.
// Ports:
//   clk, reset (async, active low)
//   fetchValid, pcAddress, cacheHit : fetch-stage request and hit result
//   mem                             : beat-read bus (master side)
//   writeCache/Index/Tag/Data       : one-cycle cache fill
//   fetchStall                      : fetch must hold pcAddress
//   missCount                       : saturating miss counter
module icache_refill_controller #(
    parameter int unsigned INDEX_BITS  = 4,
    parameter int unsigned TAG_BITS    = 25,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fetchValid,
    input  logic [31:0]                   pcAddress,
    input  logic                          cacheHit,
    icache_refill_controller_if.master    mem,
    output logic                          writeCache,
    output logic [INDEX_BITS-1:0]         writeIndex,
    output logic [TAG_BITS-1:0]           writeTag,
    output logic [63:0]                   writeData,
    output logic                          fetchStall,
    output logic [COUNT_WIDTH-1:0]        missCount
);

    import icache_pkg::*;

    refill_state_e           state_q, state_d;
    logic [31:0]             line_addr_q, line_addr_d;
    logic [31:0]             lo_q, lo_d;
    logic [COUNT_WIDTH-1:0]  miss_count_q, miss_count_d;
    logic                    mem_req_q, mem_req_d;
    logic [31:0]             mem_addr_q, mem_addr_d;
    logic                    write_cache_q, write_cache_d;
    logic [INDEX_BITS-1:0]   write_index_q, write_index_d;
    logic [TAG_BITS-1:0]     write_tag_q, write_tag_d;
    // Holds {hi, lo} only during FILL; the high beat is captured straight into it.
    logic [63:0]             write_data_q, write_data_d;

    logic        miss;
    logic [31:0] miss_line;
    logic        unused_offset;

    assign miss          = fetchValid & ~cacheHit;
    assign miss_line     = {pcAddress[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign unused_offset = ^pcAddress[OFFSET_BITS-1:0];

    always_comb begin
        state_d       = state_q;
        line_addr_d   = line_addr_q;
        lo_d          = lo_q;
        miss_count_d  = miss_count_q;
        // Outputs are pulses/qualified values: default to idle levels.
        mem_req_d     = 1'b0;
        mem_addr_d    = '0;
        write_cache_d = 1'b0;
        write_index_d = '0;
        write_tag_d   = '0;
        write_data_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (miss) begin
                    line_addr_d = miss_line;
                    if (miss_count_q != {COUNT_WIDTH{1'b1}}) begin
                        miss_count_d = miss_count_q + 1'b1;
                    end
                    mem_req_d  = 1'b1;
                    mem_addr_d = miss_line;
                    state_d    = StReqLo;
                end
            end
            StReqLo: begin
                if (mem.memReady) begin
                    state_d = StWaitLo;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = line_addr_q;
                end
            end
            StWaitLo: begin
                if (mem.memRespValid) begin
                    lo_d       = mem.memRespData;
                    mem_req_d  = 1'b1;
                    mem_addr_d = line_addr_q + BEAT_BYTES;
                    state_d    = StReqHi;
                end
            end
            StReqHi: begin
                if (mem.memReady) begin
                    state_d = StWaitHi;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = line_addr_q + BEAT_BYTES;
                end
            end
            StWaitHi: begin
                if (mem.memRespValid) begin
                    write_cache_d = 1'b1;
                    write_index_d = line_addr_q[INDEX_LSB +: INDEX_BITS];
                    write_tag_d   = line_addr_q[INDEX_LSB + INDEX_BITS +: TAG_BITS];
                    write_data_d  = {mem.memRespData, lo_q};
                    state_d       = StFill;
                end
            end
            StFill: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            line_addr_q   <= '0;
            lo_q          <= '0;
            miss_count_q  <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            write_cache_q <= 1'b0;
            write_index_q <= '0;
            write_tag_q   <= '0;
            write_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            line_addr_q   <= line_addr_d;
            lo_q          <= lo_d;
            miss_count_q  <= miss_count_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            write_cache_q <= write_cache_d;
            write_index_q <= write_index_d;
            write_tag_q   <= write_tag_d;
            write_data_q  <= write_data_d;
        end
    end

    assign mem.memReq  = mem_req_q;
    assign mem.memAddr = mem_addr_q;
    assign writeCache  = write_cache_q;
    assign writeIndex  = write_index_q;
    assign writeTag    = write_tag_q;
    assign writeData   = write_data_q;
    assign missCount   = miss_count_q;
    // Combinational so the detection cycle itself is already stalled.
    assign fetchStall  = (state_q != StIdle) | miss;

endmodule

// File: tb/tb_icache_refill_controller.sv
module tb_icache_refill_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] pc_address;
    logic        cache_hit;
    logic        mem_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    logic        write_cache, write_cache2;
    logic [3:0]  write_index, write_index2;
    logic [24:0] write_tag, write_tag2;
    logic [63:0] write_data, write_data2;
    logic        fetch_stall, fetch_stall2;
    logic [15:0] miss_count;
    logic [1:0]  miss_count2;

    int checks = 0;
    int errors = 0;

    icache_refill_controller_if mif ();
    icache_refill_controller_if mif2 ();

    assign mif.memReady      = mem_ready;
    assign mif.memRespValid  = mem_resp_valid;
    assign mif.memRespData   = mem_resp_data;
    assign mif2.memReady     = mem_ready;
    assign mif2.memRespValid = mem_resp_valid;
    assign mif2.memRespData  = mem_resp_data;

    always #5 clk = ~clk;

    icache_refill_controller dut (
        .clk        (clk),
        .reset      (reset),
        .fetchValid (fetch_valid),
        .pcAddress  (pc_address),
        .cacheHit   (cache_hit),
        .mem        (mif.master),
        .writeCache (write_cache),
        .writeIndex (write_index),
        .writeTag   (write_tag),
        .writeData  (write_data),
        .fetchStall (fetch_stall),
        .missCount  (miss_count)
    );

    icache_refill_controller #(
        .COUNT_WIDTH (2)
    ) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .fetchValid (fetch_valid),
        .pcAddress  (pc_address),
        .cacheHit   (cache_hit),
        .mem        (mif2.master),
        .writeCache (write_cache2),
        .writeIndex (write_index2),
        .writeTag   (write_tag2),
        .writeData  (write_data2),
        .fetchStall (fetch_stall2),
        .missCount  (miss_count2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full refill with memReady=1 and one-cycle response latency.
    // Starts in IDLE, ends one cycle into FILL.
    task automatic refill(input logic [31:0] pc, input logic [31:0] next_pc,
                          input logic [31:0] lo, input logic [31:0] hi,
                          input logic [3:0] idx, input logic [24:0] tag,
                          input logic [15:0] cnt);
        fetch_valid    = 1'b1;
        pc_address     = pc;
        cache_hit      = 1'b0;
        mem_ready      = 1'b1;
        mem_resp_valid = 1'b0;
        #1;
        check("detect_stall", fetch_stall, 1);
        tick();
        check("reqlo_req", mif.memReq, 1);
        check("reqlo_addr", mif.memAddr, {pc[31:3], 3'b000});
        check("reqlo_count", miss_count, cnt);
        pc_address = next_pc;
        tick();
        check("waitlo_req", mif.memReq, 0);
        check("waitlo_stall", fetch_stall, 1);
        mem_resp_valid = 1'b1;
        mem_resp_data  = lo;
        tick();
        mem_resp_valid = 1'b0;
        check("reqhi_req", mif.memReq, 1);
        check("reqhi_addr", mif.memAddr, {pc[31:3], 3'b100});
        tick();
        check("waithi_req", mif.memReq, 0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = hi;
        tick();
        mem_resp_valid = 1'b0;
        check("fill_strobe", write_cache, 1);
        check("fill_index", write_index, idx);
        check("fill_tag", write_tag, tag);
        check("fill_data", write_data, {hi, lo});
        check("fill_stall", fetch_stall, 1);
    endtask

    initial begin
        reset          = 1'b0;
        fetch_valid    = 1'b0;
        pc_address     = '0;
        cache_hit      = 1'b0;
        mem_ready      = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        tick();
        tick();
        check("rst_req", mif.memReq, 0);
        check("rst_addr", mif.memAddr, 0);
        check("rst_wc", write_cache, 0);
        check("rst_idx", write_index, 0);
        check("rst_tag", write_tag, 0);
        check("rst_data", write_data, 0);
        check("rst_stall", fetch_stall, 0);
        check("rst_count", miss_count, 0);
        reset = 1'b1;
        tick();
        // fetchValid=0 with cacheHit=0 in IDLE does nothing.
        tick();
        check("novalid_req", mif.memReq, 0);
        check("novalid_count", miss_count, 0);

        // Cold miss at 0x84: index 0, tag 1.
        refill(32'h0000_0084, 32'h0000_0084, 32'h1111_1111, 32'h2222_2222,
               4'd0, 25'h1, 16'd1);
        cache_hit = 1'b1;
        #1;
        tick();
        check("cold_wc_off", write_cache, 0);
        check("cold_data_off", write_data, 0);
        check("cold_stall_off", fetch_stall, 0);
        check("cold_req_off", mif.memReq, 0);
        tick();
        check("cold_wc_once", write_cache, 0);

        // Backpressure at 0x3C8: index 9, tag 7; spurious response in REQ_HI.
        cache_hit = 1'b0;
        pc_address = 32'h0000_03C8;
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("bp_req", mif.memReq, 1);
            check("bp_addr", mif.memAddr, 32'h3C8);
            tick();
        end
        check("bp_req_last", mif.memReq, 1);
        mem_ready = 1'b1;
        tick();
        check("bp_accepted", mif.memReq, 0);
        tick();
        check("bp_no_dup", mif.memReq, 0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hAAAA_0001;
        tick();
        check("bp_reqhi_addr", mif.memAddr, 32'h3CC);
        mem_ready      = 1'b0;
        mem_resp_data  = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid = 1'b0;
        check("spur_reqhi_req", mif.memReq, 1);
        check("spur_reqhi_addr", mif.memAddr, 32'h3CC);
        check("spur_reqhi_wc", write_cache, 0);
        mem_ready = 1'b1;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBBBB_0002;
        tick();
        mem_resp_valid = 1'b0;
        check("bp_fill_wc", write_cache, 1);
        check("bp_fill_idx", write_index, 9);
        check("bp_fill_tag", write_tag, 7);
        check("bp_fill_data", write_data, 64'hBBBB_0002_AAAA_0001);
        check("bp_count", miss_count, 2);
        cache_hit = 1'b1;
        tick();
        // Spurious response in IDLE.
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid = 1'b0;
        check("spur_idle_req", mif.memReq, 0);
        check("spur_idle_wc", write_cache, 0);
        check("spur_idle_stall", fetch_stall, 0);
        tick();
        check("spur_idle_wc2", write_cache, 0);

        // Reset during WAIT_HI.
        cache_hit = 1'b0;
        pc_address = 32'h0000_0500;
        tick();
        check("mid_count", miss_count, 3);
        fetch_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h7777_7777;
        tick();
        mem_resp_valid = 1'b0;
        tick();
        check("mid_waithi_stall", fetch_stall, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_stall", fetch_stall, 0);
        check("mid_rst_count", miss_count, 0);
        check("mid_rst_req", mif.memReq, 0);
        tick();
        reset = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h9999_9999;
        tick();
        mem_resp_valid = 1'b0;
        check("mid_late_wc", write_cache, 0);
        check("mid_late_req", mif.memReq, 0);
        check("mid_late_stall", fetch_stall, 0);
        tick();
        check("mid_late_wc2", write_cache, 0);
        check("mid_late_count", miss_count, 0);

        // Back-to-back: PC moves to 0x208 during the first refill.
        refill(32'h0000_0100, 32'h0000_0208, 32'h3333_3333, 32'h4444_4444,
               4'd0, 25'h2, 16'd1);
        tick();
        check("b2b_idle_req", mif.memReq, 0);
        check("b2b_idle_stall", fetch_stall, 1);
        refill(32'h0000_0208, 32'h0000_0208, 32'h5555_5555, 32'h6666_6666,
               4'd1, 25'h4, 16'd2);
        cache_hit = 1'b1;
        tick();
        check("b2b_count", miss_count, 2);

        // Saturation on the 2-bit counter instance.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            refill(32'h0000_1000 + 32'(i * 8), 32'h0000_1000 + 32'(i * 8),
                   32'h0101_0000 + 32'(i), 32'h0202_0000 + 32'(i),
                   4'(i), 25'h20, 16'(i + 1));
            check("sat_count", miss_count2, (i < 2) ? 2'(i + 1) : 2'd3);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
